// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard tracker.
//   fwd_sel_t : operand mux select (regfile / EX result / MEM result)
//   XZR       : zero register number; never a real producer or consumer
//   REG_W     : register number width
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/reg_match.sv
// reg_match: qualified register compare between a consumer source register
// and a tracked producer destination.
// Ports:
//   src  in  source register of the decode instruction
//   dst  in  destination register held in a pipeline shadow stage
//   wr   in  shadow stage will write dst
//   hit  out src is produced by that stage (never true for XZR)
module reg_match
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] dst,
    input  logic             wr,
    output logic             hit
);

    assign hit = wr && (src == dst) && (src != XZR);

endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks destinations of instructions in EX and MEM and
// resolves operand hazards for the instruction in decode.
// Ports:
//   clk          in   pipeline clock
//   reset        in   asynchronous active-high clear of all tracked state
//   id_valid     in   decode slot holds a real instruction
//   id_rs1       in   first source register
//   id_rs2       in   second source register
//   id_rd        in   destination register of decode instruction
//   id_reg_write in   decode instruction writes id_rd
//   id_mem_read  in   decode instruction is a load
//   flush        in   squash decode instruction
//   fwd_a        out  operand-A select (00 regfile, 01 EX, 10 MEM)
//   fwd_b        out  operand-B select, same encoding
//   stall        out  load-use stall: hold PC and IF/ID, bubble into EX
//   stall_count  out  saturating count of stall cycles since reset
//
// Flow semantics: the decode instruction is "accepted" into EX on a rising
// edge when id_valid=1, stall=0 and flush=0; in every other cycle a bubble
// (no write, no load, rd=XZR) is captured into EX instead. The MEM shadow
// follows EX unconditionally.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Shadow of the instruction now in EX and in MEM.
    logic [REG_W-1:0] ex_rd;
    logic             ex_wr;
    logic             ex_ld;
    logic [REG_W-1:0] mem_rd;
    logic             mem_wr;

    logic a_ex_hit, a_mem_hit, b_ex_hit, b_mem_hit;
    fwd_sel_t sel_a, sel_b;
    logic advance;

    reg_match u_a_ex  (.src(id_rs1), .dst(ex_rd),  .wr(ex_wr),  .hit(a_ex_hit));
    reg_match u_a_mem (.src(id_rs1), .dst(mem_rd), .wr(mem_wr), .hit(a_mem_hit));
    reg_match u_b_ex  (.src(id_rs2), .dst(ex_rd),  .wr(ex_wr),  .hit(b_ex_hit));
    reg_match u_b_mem (.src(id_rs2), .dst(mem_rd), .wr(mem_wr), .hit(b_mem_hit));

    // EX is checked first: the youngest producer holds the current value.
    always_comb begin
        sel_a = FWD_REG;
        sel_b = FWD_REG;
        stall = 1'b0;
        if (id_valid) begin
            if (a_ex_hit)       sel_a = FWD_EX;
            else if (a_mem_hit) sel_a = FWD_MEM;
            if (b_ex_hit)       sel_b = FWD_EX;
            else if (b_mem_hit) sel_b = FWD_MEM;
            stall = ex_ld && (a_ex_hit || b_ex_hit);
        end
    end

    assign fwd_a   = sel_a;
    assign fwd_b   = sel_b;
    assign advance = id_valid && !stall && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rd  <= XZR;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            mem_rd <= XZR;
            mem_wr <= 1'b0;
        end else begin
            mem_rd <= ex_rd;
            mem_wr <= ex_wr;
            if (advance) begin
                ex_rd <= id_rd;
                ex_wr <= id_reg_write && (id_rd != XZR);
                ex_ld <= id_mem_read;
            end else begin
                ex_rd <= XZR;
                ex_wr <= 1'b0;
                ex_ld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed test of hazard_tracker with a default-width
// instance and a CNT_W=2 instance sharing the same stimulus.
// Inputs change 1 ns after a rising edge; outputs are sampled 2 ns later.
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic [4:0]  id_rd = 5'd0;
    logic        id_reg_write = 1'b0;
    logic        id_mem_read = 1'b0;
    logic        flush = 1'b0;

    logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic        stall, stall2;
    logic [15:0] stall_count;
    logic [1:0]  stall_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_tracker dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
    );

    hazard_tracker #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a(fwd_a2),
        .fwd_b(fwd_b2), .stall(stall2), .stall_count(stall_count2)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr, input logic ld,
                         input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = wr; id_mem_read = ld; flush = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got %b exp 00", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got %b exp 00", fwd_b); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", stall_count); end
        tick();
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_held_fwd_a got %b exp 00", fwd_a); end
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_ex_forward();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);   // ADD X3
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL ex_pre_fwd_a got %b exp 00", fwd_a); end
        tick();
        drive(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL ex_fwd_a got %b exp 01", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL ex_fwd_b got %b exp 00", fwd_b); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ex_stall got %b exp 0", stall); end
        // Same hazard but decode slot empty: selects must read 00.
        drive(1'b0, 5'd3, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL ex_invalid_fwd_a got %b exp 00", fwd_a); end
        tick();
    endtask

    task automatic test_mem_forward();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd5, 5'd12, 1'b1, 1'b0, 1'b0);
        checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL mem_fwd_b got %b exp 10", fwd_b); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL mem_fwd_a got %b exp 00", fwd_a); end
        tick();
        // Producer now three cycles old: invisible.
        drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL mem_expired_fwd_a got %b exp 00", fwd_a); end
        // Priority: rd=5 in both EX and MEM.
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL prio_fwd_a got %b exp 01", fwd_a); end
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL prio_fwd_b got %b exp 01", fwd_b); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);   // LDUR X7
        tick();
        drive(1'b1, 5'd7, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_stall_fwd_a got %b exp 01", fwd_a); end
        tick();
        // Re-decode: load now in MEM, EX must hold the bubble (rs2=8 unmatched).
        drive(1'b1, 5'd7, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_retry_stall got %b exp 0", stall); end
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL lu_retry_fwd_a got %b exp 10", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd_b got %b exp 00", fwd_b); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", stall_count); end
        tick();
        drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_consumer_fwd_a got %b exp 01", fwd_a); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_hold got %0d exp 1", stall_count); end
        tick();
    endtask

    task automatic test_xzr_and_wr();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL xzr_fwd_a got %b exp 00", fwd_a); end
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);   // STUR-like, no write
        tick();
        drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL nowr_fwd_a got %b exp 00", fwd_a); end
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0);  // load to XZR
        tick();
        drive(1'b1, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL xzr_load_stall got %b exp 0", stall); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL xzr_load_fwd_b got %b exp 00", fwd_b); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL flush_fwd_a got %b exp 00", fwd_a); end
        tick();
        drive(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL flush_mem_fwd_a got %b exp 00", fwd_a); end
        // Flush together with stall.
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flst_stall got %b exp 1", stall); end
        tick();
        drive(1'b1, 5'd7, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flst_retry_stall got %b exp 0", stall); end
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL flst_fwd_a got %b exp 10", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL flst_bubble_fwd_b got %b exp 00", fwd_b); end
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL flst_count got %0d exp 1", stall_count); end
        tick();
        drive(1'b1, 5'd7, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL flst_mem_bubble_fwd_a got %b exp 00", fwd_a); end
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL flst_consumer_fwd_b got %b exp 01", fwd_b); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        // Chain of dependent loads: each one stalls once, then retires.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d] got %b exp 1", i, stall); end
            tick();
            drive(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_retry[%0d] got %b exp 0", i, stall); end
            if (i == 2) begin
                checks++; if (stall_count2 !== 2'd3) begin errors++; $display("FAIL sat_at3 got %0d exp 3", stall_count2); end
            end
            tick();
        end
        checks++; if (stall_count !== 16'd5) begin errors++; $display("FAIL b2b_count got %0d exp 5", stall_count); end
        checks++; if (stall_count2 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d exp 3", stall_count2); end
        // Reset while a stall is in progress, between clock edges.
        drive(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got %b exp 1", stall); end
        #1 reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall got %b exp 0", stall); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL mid_fwd_a got %b exp 00", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL mid_fwd_b got %b exp 00", fwd_b); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", stall_count); end
        checks++; if (stall_count2 !== 2'd0) begin errors++; $display("FAIL mid_count_sat got %0d exp 0", stall_count2); end
        #1 reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_xzr_and_wr();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
